// File: rtl/itlb.sv
// itlb: fully-associative instruction TLB (4 KiB pages) with a single-level page-table walk; ITLB_PERF_CNT_EN adds HIT_COUNT/MISS_COUNT.
// Latency: a hit translates in the same cycle. A miss costs 3 cycles with a 1-cycle PTE responder: request, capture, then hit.
// Backpressure: CURR_ADDR advances only on a valid translation. One walk is outstanding at a time, and the TLB waits indefinitely for its PTE.
module itlb #(
  parameter logic [31:0] virt_addr_init = 32'h0001_0000,
  parameter int          ENTRIES        = 8,
  parameter logic [31:0] PT_BASE        = 32'h0040_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TLB_FLUSH,
  input  logic [31:0] VIRT_ADDR,
  input  logic        VIRT_ADDR_VALID,
  output logic [31:0] CURR_ADDR,
  output logic        PHY_ADDR_VALID,
  output logic [31:0] PHY_ADDR,
  output logic        ADDR_TO_AXIM_VALID,
  output logic [31:0] ADDR_TO_AXIM,
  input  logic        DATA_FROM_AXIM_VALID,
  input  logic [31:0] DATA_FROM_AXIM
`ifdef ITLB_PERF_CNT_EN
  ,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
`endif
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {LOOKUP, REQ, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic          ent_vld [ENTRIES];
  logic [19:0]   ent_vpn [ENTRIES];
  logic [19:0]   ent_ppn [ENTRIES];
  logic [PW-1:0] rr_ptr;
  logic          hit;
  logic [19:0]   hit_ppn;
  logic [19:0]   curr_vpn;
  logic          miss_start;
  logic          refill;
  logic          unused_pte_hi;

  assign curr_vpn      = CURR_ADDR[31:12];
  assign unused_pte_hi = ^DATA_FROM_AXIM[31:20];

  // associative compare; refill only follows a miss, so at most one entry matches and OR-merging the PPNs is exact
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_vld[i] && (ent_vpn[i] == curr_vpn)) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | ent_ppn[i];
      end
    end
  end

  // next state, translation strobe, and walk start/finish events
  always_comb begin
    state_nxt      = state;
    PHY_ADDR_VALID = 1'b0;
    miss_start     = 1'b0;
    refill         = 1'b0;
    case (state)
      LOOKUP: begin
        if (!TLB_FLUSH && !RST) begin
          if (hit) begin
            PHY_ADDR_VALID = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_nxt  = REQ;
          end
        end
      end
      REQ: state_nxt = TLB_FLUSH ? DROP : WAIT;
      WAIT: begin
        // A flush that coincides with the PTE discards the PTE here.
        // Going to DROP would wait for a response that has already been consumed.
        if (DATA_FROM_AXIM_VALID) begin
          state_nxt = LOOKUP;
          refill    = !TLB_FLUSH;
        end else if (TLB_FLUSH) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (DATA_FROM_AXIM_VALID) state_nxt = LOOKUP;
      end
      default: state_nxt = LOOKUP;
    endcase
  end

  assign PHY_ADDR           = PHY_ADDR_VALID ? {hit_ppn, CURR_ADDR[11:0]} : '0;
  assign ADDR_TO_AXIM_VALID = (state == REQ) && !RST;

  // FSM state, fetch address, and PTE request address (captured when a miss is detected, then held)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= LOOKUP;
      CURR_ADDR    <= virt_addr_init;
      ADDR_TO_AXIM <= '0;
    end else begin
      state <= state_nxt;
      if (PHY_ADDR_VALID && VIRT_ADDR_VALID) CURR_ADDR <= VIRT_ADDR;
      if (miss_start) ADDR_TO_AXIM <= {PT_BASE[31:22], curr_vpn, 2'b00};
    end
  end

  // entry array: flush clears valid bits only, refill writes at the round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_vld[i] <= 1'b0;
    end else if (TLB_FLUSH) begin
      for (int i = 0; i < ENTRIES; i++) ent_vld[i] <= 1'b0;
    end else if (refill) begin
      ent_vld[rr_ptr] <= 1'b1;
      ent_vpn[rr_ptr] <= curr_vpn;
      ent_ppn[rr_ptr] <= DATA_FROM_AXIM[19:0];
      rr_ptr          <= (rr_ptr == PW'(ENTRIES - 1)) ? '0 : rr_ptr + PW'(1);
    end
  end

`ifdef ITLB_PERF_CNT_EN
  // free-running hit/miss counters; they survive a flush and clear only on reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (PHY_ADDR_VALID) HIT_COUNT <= HIT_COUNT + 32'd1;
      if (miss_start) MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`else
  // no performance counters in this build
`endif

endmodule

// File: tb/tb_itlb.sv
// tb_itlb: directed test-plan steps, then a randomized run against a page-level TLB reference model.
// Latency: one DUT cycle per call to cycle(); each PTE responder reply comes 1..3 cycles after its request.
// Backpressure: none; the bench drives VIRT_ADDR_VALID and the PTE responder freely.
module tb_itlb;

  localparam int          N    = 8;
  localparam logic [31:0] PTB  = 32'h0040_0000;
  localparam logic [31:0] INIT = 32'h0001_0000;
  localparam int PH_XLATE = 0, PH_REQ = 1, PH_AWAIT = 2, PH_DISCARD = 3;

  logic        CLK, RST, TLB_FLUSH, VIRT_ADDR_VALID, DATA_FROM_AXIM_VALID;
  logic [31:0] VIRT_ADDR, DATA_FROM_AXIM;
  logic [31:0] CURR_ADDR, PHY_ADDR, ADDR_TO_AXIM;
  logic        PHY_ADDR_VALID, ADDR_TO_AXIM_VALID;
`ifdef ITLB_PERF_CNT_EN
  logic [31:0] HIT_COUNT, MISS_COUNT;
`endif

  itlb dut (
    .CLK(CLK), .RST(RST), .TLB_FLUSH(TLB_FLUSH),
    .VIRT_ADDR(VIRT_ADDR), .VIRT_ADDR_VALID(VIRT_ADDR_VALID),
    .CURR_ADDR(CURR_ADDR), .PHY_ADDR_VALID(PHY_ADDR_VALID), .PHY_ADDR(PHY_ADDR),
    .ADDR_TO_AXIM_VALID(ADDR_TO_AXIM_VALID), .ADDR_TO_AXIM(ADDR_TO_AXIM),
    .DATA_FROM_AXIM_VALID(DATA_FROM_AXIM_VALID), .DATA_FROM_AXIM(DATA_FROM_AXIM)
`ifdef ITLB_PERF_CNT_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: page mappings held in slots, round-robin fill, walk phase
  bit          m_v [N];
  logic [19:0] m_vpn [N];
  logic [19:0] m_ppn [N];
  int          m_ptr;
  logic [31:0] m_curr;
  int          m_phase;
  int          m_hits, m_misses;

  // PTE responder and stimulus controls
  int          rsp_cd, rsp_dly;
  bit          rand_dly, stray_now, stray_rand;
  logic [31:0] rsp_addr, key;
  int          n_req;

  // per-cycle observations, used by the directed steps
  logic        o_pv, o_req;
  logic [31:0] o_pa, o_curr, o_raddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [19:0] vpn);
    for (int i = 0; i < N; i++) if (m_v[i] && m_vpn[i] == vpn) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_ptr = 0; m_curr = INIT; m_phase = PH_XLATE; m_hits = 0; m_misses = 0;
    rsp_cd = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1; TLB_FLUSH = 1'b0; VIRT_ADDR_VALID = 1'b0; VIRT_ADDR = '0;
    DATA_FROM_AXIM_VALID = 1'b0; DATA_FROM_AXIM = '0;
    @(posedge CLK); #1; @(posedge CLK); #1;
    chk("rst_curr", CURR_ADDR, INIT);
    chk("rst_pv", 32'(PHY_ADDR_VALID), 32'd0);
    chk("rst_pa", PHY_ADDR, 32'd0);
    chk("rst_req", 32'(ADDR_TO_AXIM_VALID), 32'd0);
    chk("rst_raddr", ADDR_TO_AXIM, 32'd0);
`ifdef ITLB_PERF_CNT_EN
    chk("rst_hitcnt", HIT_COUNT, 32'd0);
    chk("rst_misscnt", MISS_COUNT, 32'd0);
`endif
    RST = 1'b0;
    model_reset();
  endtask

  // one clock: drive inputs, check all outputs against the model, advance the model, cross the edge
  task automatic cycle(input bit fl, input bit vav, input logic [31:0] va, input bit seq);
    int  h;
    bit  e_pv;
    TLB_FLUSH       = fl;
    VIRT_ADDR_VALID = vav;
    VIRT_ADDR       = seq ? m_curr + 32'd4 : va;
    if (rsp_cd == 1) begin
      DATA_FROM_AXIM_VALID = 1'b1;
      DATA_FROM_AXIM       = (rsp_addr >> 2) ^ key;
    end else if (rsp_cd == 0 && m_phase == PH_XLATE &&
                 (stray_now || (stray_rand && $urandom_range(0, 9) == 0))) begin
      DATA_FROM_AXIM_VALID = 1'b1;
      DATA_FROM_AXIM       = $urandom;
    end else begin
      DATA_FROM_AXIM_VALID = 1'b0;
      DATA_FROM_AXIM       = $urandom;
    end
    if (rsp_cd > 0) rsp_cd--;
    #1;
    h    = m_find(m_curr[31:12]);
    e_pv = (m_phase == PH_XLATE) && (h >= 0) && !fl;
    o_pv = PHY_ADDR_VALID; o_pa = PHY_ADDR; o_curr = CURR_ADDR;
    o_req = ADDR_TO_AXIM_VALID; o_raddr = ADDR_TO_AXIM;
    chk("curr", CURR_ADDR, m_curr);
    chk("pv", 32'(PHY_ADDR_VALID), 32'(e_pv));
    if (e_pv) chk("pa", PHY_ADDR, {m_ppn[h], m_curr[11:0]});
    chk("req_vld", 32'(ADDR_TO_AXIM_VALID), 32'(m_phase == PH_REQ));
    if (m_phase == PH_REQ) chk("req_addr", ADDR_TO_AXIM, {PTB[31:22], m_curr[31:12], 2'b00});
    if (ADDR_TO_AXIM_VALID) begin
      n_req++;
      rsp_addr = ADDR_TO_AXIM;
      rsp_cd   = rand_dly ? $urandom_range(1, 3) : rsp_dly;
    end
    if (e_pv) m_hits++;
    if (fl) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      if (m_phase == PH_REQ) m_phase = PH_DISCARD;
      else if (m_phase == PH_AWAIT || m_phase == PH_DISCARD)
        m_phase = DATA_FROM_AXIM_VALID ? PH_XLATE : PH_DISCARD;
    end else begin
      case (m_phase)
        PH_XLATE: begin
          if (h >= 0) begin
            if (vav) m_curr = VIRT_ADDR;
          end else begin
            m_phase = PH_REQ;
            m_misses++;
          end
        end
        PH_REQ: m_phase = PH_AWAIT;
        PH_AWAIT: if (DATA_FROM_AXIM_VALID) begin
          m_v[m_ptr] = 1'b1; m_vpn[m_ptr] = m_curr[31:12]; m_ppn[m_ptr] = DATA_FROM_AXIM[19:0];
          m_ptr = (m_ptr + 1) % N;
          m_phase = PH_XLATE;
        end
        default: if (DATA_FROM_AXIM_VALID) m_phase = PH_XLATE;
      endcase
    end
    @(posedge CLK); #1;
  endtask

  task automatic run_until_pv(input int max, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      if (o_pv === 1'b1) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic visit(input logic [31:0] target, output int nreq);
    int r0 = n_req;
    bit got = 1'b0;
    for (int i = 0; i < 24 && !got; i++) begin
      cycle(1'b0, 1'b1, target, 1'b0);
      if (o_pv === 1'b1 && o_curr === target) got = 1'b1;
    end
    chk("visit_reach", 32'(got), 32'd1);
    nreq = n_req - r0;
  endtask

  initial begin
    int r, nr;
    logic [31:0] va;
    key = '0; rsp_dly = 1; rand_dly = 1'b0; stray_now = 1'b0; stray_rand = 1'b0; n_req = 0;
    do_reset();

    // boot miss: request in n+1, capture in n+2, hit in n+3
    cycle(1'b0, 1'b1, 32'd0, 1'b1); chk("boot_miss_pv", 32'(o_pv), 32'd0);
    cycle(1'b0, 1'b1, 32'd0, 1'b1); chk("boot_req", 32'(o_req), 32'd1);
    chk("boot_raddr", o_raddr, 32'h0040_0040);
    cycle(1'b0, 1'b1, 32'd0, 1'b1); chk("boot_req_pulse", 32'(o_req), 32'd0);
    cycle(1'b0, 1'b1, 32'd0, 1'b1); chk("boot_hit_pv", 32'(o_pv), 32'd1);
    chk("boot_hit_pa", o_pa, 32'h0001_0000);

    // sequential fetch: one translation per cycle, identity map, no requests
    r = n_req;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 32'd0, 1'b1);
      chk("seq_pv", 32'(o_pv), 32'd1);
      chk("seq_pa", o_pa, 32'h0001_0004 + 32'(4 * i));
    end
    chk("seq_noreq", 32'(n_req - r), 32'd0);

    // jump to another page, then return to the first page without a walk
    cycle(1'b0, 1'b1, 32'h1001_0000, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0); chk("jump_miss_pv", 32'(o_pv), 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0); chk("jump_req", 32'(o_req), 32'd1);
    chk("jump_raddr", o_raddr, 32'h0044_0040);
    run_until_pv(6, "jump_walk_done");
    chk("jump_pa", o_pa, 32'h1001_0000);
    r = n_req;
    cycle(1'b0, 1'b1, 32'h0001_0100, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("ret_pv", 32'(o_pv), 32'd1);
    chk("ret_pa", o_pa, 32'h0001_0100);
    chk("ret_noreq", 32'(n_req - r), 32'd0);

    // flush while hitting: no translation, no advance, then re-walk of the same VPN
    cycle(1'b1, 1'b1, 32'h0001_0200, 1'b0); chk("fl_pv", 32'(o_pv), 32'd0);
    cycle(1'b0, 1'b1, 32'h0001_0200, 1'b0);
    chk("fl_curr_hold", o_curr, 32'h0001_0100);
    chk("fl_miss_pv", 32'(o_pv), 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0); chk("fl_req", 32'(o_req), 32'd1);
    chk("fl_raddr", o_raddr, 32'h0040_0040);
    run_until_pv(6, "fl_walk_done");
    chk("fl_pa", o_pa, 32'h0001_0100);

    // flush during WAIT: the late PTE is discarded and the same VPN is walked again
    rsp_dly = 2;
    cycle(1'b0, 1'b1, 32'h2000_3000, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0); chk("wf_req", 32'(o_req), 32'd1);
    r = n_req;
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    run_until_pv(12, "wf_walk_done");
    chk("wf_rewalk_cnt", 32'(n_req - r), 32'd1);
    chk("wf_raddr", o_raddr, 32'h0048_000C);
    chk("wf_pa", o_pa, 32'h2000_3000);

    // reset mid-walk, then a stray PTE arriving in LOOKUP is ignored
    cycle(1'b0, 1'b1, 32'h3000_0000, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    do_reset();
    rsp_dly = 1;
    stray_now = 1'b1;
    cycle(1'b0, 1'b0, 32'd0, 1'b0); chk("stray_pv", 32'(o_pv), 32'd0);
    stray_now = 1'b0;
    cycle(1'b0, 1'b0, 32'd0, 1'b0); chk("stray_req", 32'(o_req), 32'd1);
    run_until_pv(6, "stray_walk_done");
    chk("stray_pa", o_pa, 32'h0001_0000);

    // nine pages into eight entries: the ninth refill evicts the first page only
    do_reset();
    visit(INIT, nr); chk("evict_fill0", 32'(nr), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      visit(32'h0100_0000 + (32'(k) << 12), nr);
      chk("evict_fill", 32'(nr), 32'd1);
    end
    visit(32'h0100_1000, nr); chk("evict_second_hits", 32'(nr), 32'd0);
    visit(INIT, nr); chk("evict_first_misses", 32'(nr), 32'd1);

    // randomized run: non-identity PTEs, variable PTE latency, flushes, stray responses
    key = $urandom; rand_dly = 1'b1; stray_rand = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      va = 32'h5000_0000 | (32'($urandom_range(0, 11)) << 12) | ($urandom & 32'h0000_0FFC);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, va, $urandom_range(0, 2) == 0);
    end
`ifdef ITLB_PERF_CNT_EN
    chk("hit_count", HIT_COUNT, 32'(m_hits));
    chk("miss_count", MISS_COUNT, 32'(m_misses));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
